// File: rtl/cache_pkg.sv
// Shared types and constants for the main-memory arbiter.
package cache_pkg;

  localparam int AW          = 16;
  localparam int DW          = 16;
  localparam int WORDS       = 8;
  localparam int BLOCK_BYTES = 16;
  localparam int OFFSET_W    = 4;
  localparam int MEM_LATENCY = 4;
  // Counters must reach WORDS itself so "iss < WORDS" can go false.
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

  // Block-aligned address: the low OFFSET_W bits select a byte inside the block.
  function automatic logic [AW-1:0] block_base(input logic [AW-1:0] addr);
    return {addr[AW-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

  // Byte address of 16-bit word idx within the block at base.
  function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] base,
                                              input logic [CNT_W-1:0] idx);
    return base + {{(AW-CNT_W-1){1'b0}}, idx, 1'b0};
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/fill signals and the main-memory bus of the arbiter.
// master = arbiter side, slave = caches plus memory.
interface mem_arbiter_if;
  import cache_pkg::*;

  logic          i_miss;
  logic [AW-1:0] i_miss_addr;
  logic          d_miss;
  logic [AW-1:0] d_miss_addr;
  logic          d_wr_req;
  logic [AW-1:0] d_wr_addr;
  logic [DW-1:0] d_wr_data;
  logic          d_wr_ack;

  logic [AW-1:0] mem_addr;
  logic          mem_enable;
  logic          mem_wr;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;
  logic          mem_data_valid;

  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_data;
  logic          i_fill_we;
  logic          d_fill_we;
  logic          i_tag_we;
  logic          d_tag_we;
  logic          i_busy;
  logic          d_busy;

  modport master (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr,
    input  d_wr_req, d_wr_addr, d_wr_data,
    input  mem_data_out, mem_data_valid,
    output d_wr_ack, mem_addr, mem_enable, mem_wr, mem_data_in,
    output fill_addr, fill_data, i_fill_we, d_fill_we,
    output i_tag_we, d_tag_we, i_busy, d_busy
  );

  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr,
    output d_wr_req, d_wr_addr, d_wr_data,
    output mem_data_out, mem_data_valid,
    input  d_wr_ack, mem_addr, mem_enable, mem_wr, mem_data_in,
    input  fill_addr, fill_data, i_fill_we, d_fill_we,
    input  i_tag_we, d_tag_we, i_busy, d_busy
  );

endinterface

// File: rtl/mem_grant_pick.sv
// Combinational choice of the next memory user. A dcache fill outranks a
// dcache store; between the caches a tie goes to the one not served last.
module mem_grant_pick
  import cache_pkg::*;
(
  input  logic i_miss_i,
  input  logic d_miss_i,
  input  logic d_wr_req_i,
  input  logic last_d_i,
  output logic gnt_valid_o,
  output gnt_t gnt_cache_o,
  output logic gnt_write_o
);

  logic d_cand;
  logic i_cand;

  assign d_cand = d_miss_i | d_wr_req_i;
  assign i_cand = i_miss_i;

  // Round-robin between caches; the dcache's own miss beats its store.
  always_comb begin
    gnt_valid_o = d_cand | i_cand;
    gnt_cache_o = GNT_I;
    if (d_cand && i_cand) begin
      gnt_cache_o = last_d_i ? GNT_I : GNT_D;
    end else if (d_cand) begin
      gnt_cache_o = GNT_D;
    end
    gnt_write_o = (gnt_cache_o == GNT_D) && !d_miss_i && d_wr_req_i;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main memory between icache fills, dcache fills and
// dcache write-through stores.
//
//   state | meaning
//   IDLE  | arbitrating, no memory access
//   FILL  | issuing the 8 block reads and steering returns to the granted cache
//   WRITE | one-cycle store to memory, acknowledged to the dcache
module mem_arbiter
  import cache_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  state_t           state_q;
  logic [CNT_W-1:0] iss_q;
  logic [CNT_W-1:0] ret_q;
  logic [AW-1:0]    base_q;
  gnt_t             gnt_q;
  logic             last_d_q;
  logic             i_busy_q;
  logic             d_busy_q;

  logic pick_valid;
  gnt_t pick_cache;
  logic pick_write;

  logic issuing;
  logic ret_fire;
  logic last_ret;

  mem_grant_pick u_pick (
    .i_miss_i    (bus.i_miss),
    .d_miss_i    (bus.d_miss),
    .d_wr_req_i  (bus.d_wr_req),
    .last_d_i    (last_d_q),
    .gnt_valid_o (pick_valid),
    .gnt_cache_o (pick_cache),
    .gnt_write_o (pick_write)
  );

  // Only returns for reads already issued count; anything else is noise.
  assign issuing  = (state_q == FILL) && (iss_q < CNT_W'(WORDS));
  assign ret_fire = (state_q == FILL) && bus.mem_data_valid && (ret_q < iss_q);
  assign last_ret = ret_fire && (ret_q == CNT_W'(WORDS - 1));

  // Sequencing FSM with its counters, latched grant and registered busy flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      iss_q    <= '0;
      ret_q    <= '0;
      base_q   <= '0;
      gnt_q    <= GNT_I;
      last_d_q <= 1'b0;
      i_busy_q <= 1'b0;
      d_busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            last_d_q <= (pick_cache == GNT_D);
            if (pick_write) begin
              state_q <= WRITE;
            end else begin
              state_q  <= FILL;
              gnt_q    <= pick_cache;
              base_q   <= block_base((pick_cache == GNT_D) ? bus.d_miss_addr
                                                           : bus.i_miss_addr);
              iss_q    <= '0;
              ret_q    <= '0;
              i_busy_q <= (pick_cache == GNT_I);
              d_busy_q <= (pick_cache == GNT_D);
            end
          end
        end
        FILL: begin
          if (issuing) begin
            iss_q <= iss_q + 1'b1;
          end
          if (ret_fire) begin
            ret_q <= ret_q + 1'b1;
          end
          if (last_ret) begin
            state_q  <= IDLE;
            i_busy_q <= 1'b0;
            d_busy_q <= 1'b0;
          end
        end
        WRITE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Memory bus and cache strobes follow state, counters and the return valid.
  always_comb begin
    bus.mem_enable  = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_data_in = '0;
    bus.d_wr_ack    = 1'b0;
    bus.fill_addr   = '0;
    if (issuing) begin
      bus.mem_enable = 1'b1;
      bus.mem_addr   = word_addr(base_q, iss_q);
    end else if (state_q == WRITE) begin
      bus.mem_enable  = 1'b1;
      bus.mem_wr      = 1'b1;
      bus.mem_addr    = bus.d_wr_addr;
      bus.mem_data_in = bus.d_wr_data;
      bus.d_wr_ack    = 1'b1;
    end
    if (state_q == FILL) begin
      bus.fill_addr = word_addr(base_q, ret_q);
    end
  end

  assign bus.fill_data = bus.mem_data_out;
  assign bus.i_fill_we = ret_fire && (gnt_q == GNT_I);
  assign bus.d_fill_we = ret_fire && (gnt_q == GNT_D);
  assign bus.i_tag_we  = last_ret && (gnt_q == GNT_I);
  assign bus.d_tag_we  = last_ret && (gnt_q == GNT_D);
  assign bus.i_busy    = i_busy_q;
  assign bus.d_busy    = d_busy_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences and shares the single multi-cycle main memory between the instruction cache and the data cache. It accepts icache fill requests, dcache fill requests and dcache write-through stores, and grants one at a time. For a fill it issues the eight word reads of the block, then steers each returning word into the granted cache's data array. It raises the tag-array write on the final word and signals busy to the stalling pipeline.

## Interface
- MEM_LATENCY, 4, cycles from a memory read issue to its mem_data_valid
- WORDS, 8, 16-bit words per cache block (block = 16 bytes)
- AW, 16, address width
- DW, 16, data width

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_miss  in  1  icache fill request (level)
- i_miss_addr  in  AW  icache miss address
- d_miss  in  1  dcache fill request (level)
- d_miss_addr  in  AW  dcache miss address
- d_wr_req  in  1  dcache write-through store request
- d_wr_addr  in  AW  store address
- d_wr_data  in  DW  store data
- d_wr_ack  out  1  store accepted this cycle
- mem_addr  out  AW  memory address
- mem_enable  out  1  memory access strobe
- mem_wr  out  1  memory write
- mem_data_in  out  DW  memory write data
- mem_data_out  in  DW  memory read data
- mem_data_valid  in  1  read data valid
- fill_addr  out  AW  address of the word currently being filled
- fill_data  out  DW  word being filled (= mem_data_out)
- i_fill_we, d_fill_we  out  1 each  data-array write strobes
- i_tag_we, d_tag_we  out  1 each  tag-array write strobes
- i_busy, d_busy  out  1 each  fill in progress for that cache

## Operation
- States: IDLE, FILL, WRITE.
- IDLE arbitration, evaluated each cycle:
  - Dcache candidate: d_miss, else d_wr_req.
  - Icache candidate: i_miss.
  - If both caches request, grant the cache not granted last (`last_d` flag, reset 0, so the dcache wins the first tie).
- IDLE → FILL on a miss grant. Latch `base = addr & ~0xF` and the granted cache.
- IDLE → WRITE on a store grant.
- FILL:
  - Issue counter `iss` runs 0..7. While `iss < WORDS`, drive mem_enable=1, mem_wr=0, mem_addr=base+2·iss.
  - Return counter `ret` runs 0..7. On mem_data_valid with `ret < iss`:
    - assert the granted cache's fill_we;
    - fill_addr = base+2·ret;
    - increment `ret`.
  - On the return with `ret==WORDS-1`, also assert the granted cache's tag_we, then go to IDLE.
- WRITE: for one cycle drive mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_in=d_wr_data, d_wr_ack=1. Then go to IDLE. No response is expected.
- Miss-address bits [3:0] are ignored.
- Request deassertion during FILL is ignored; the block always completes.
- mem_data_valid outside FILL, or with `ret==iss`, is ignored: no strobes.
- Reset: all outputs 0, state IDLE, counters 0, `last_d`=0. Memory shares rst, so there are no stale returns.

## Timing
- Miss seen in IDLE at cycle 0:
  - FILL from cycle 1.
  - mem_enable high cycles 1..8.
  - fill_we cycles 1+L..8+L (L = MEM_LATENCY).
  - tag_we at cycle 8+L.
  - IDLE at cycle 9+L.
- Next grant is earliest at cycle 9+L.
- busy is registered: high cycles 1..8+L for the granted cache only.
- Store seen at cycle 0: WRITE and d_wr_ack at cycle 1; IDLE at cycle 2.
- Strobes, fill_addr and fill_data are combinational from state, counters and mem_data_valid within the cycle.
- Reset asserted mid-FILL: at the next edge all strobes drop and the fill is abandoned. The cache must re-request.

## Structure
- cache_pkg:
  - state enum;
  - WORDS, BLOCK_BYTES, OFFSET_W=4;
  - grant encoding (GNT_I, GNT_D).
- Sub-module mem_grant_pick: combinational pick from (i_miss, d_miss, d_wr_req, last_d), producing grant valid, cache and is_write.
- The counters, FSM and output muxing live in mem_arbiter.

## Test plan
- i_miss, addr 0x1234, L=4:
  - mem_addr 0x1230..0x123E on cycles 1..8;
  - i_fill_we on cycles 5..12 with fill_addr matching;
  - i_tag_we only on cycle 12;
  - i_busy cycles 1..12.
- i_miss and d_miss together at reset: dcache filled first. After its tag_we, the icache is granted at cycle 13 with no idle gap beyond one IDLE cycle.
- d_wr_req, addr 0x0040, data 0xBEEF: cycle 1 shows mem_wr=1, mem_addr=0x0040, mem_data_in=0xBEEF and d_wr_ack=1. No fill strobes.
- Spurious mem_data_valid pulses in IDLE and after the 8th return produce zero fill_we and tag_we.
- rst at cycle 6 of a fill: cycle 7 shows all outputs 0 and state IDLE. A subsequent d_miss fills normally.
- i_miss held continuously across two fills, with d_miss raised mid-fill: grants alternate D/I. Neither cache waits more than one full fill.
